// File: rtl/dmem_responder_pkg.sv
// Shared constants for the handshake data-memory responder: FSM encoding,
// memory geometry and the address-legality rule.
package dmem_responder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int MEM_BYTES = 4096;
    localparam int MEM_WORDS = 1024;
    localparam int IDX_LSB   = 2;
    localparam int IDX_MSB   = 11;
    localparam int IDX_W     = IDX_MSB - IDX_LSB + 1;

    // Legal addresses are word-aligned and fall inside the 4 KB window.
    function automatic logic addr_is_err(input logic [31:0] addr);
        return (addr[31:12] != 20'd0) || (addr[1:0] != 2'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte synchronous write and combinational read.
// Contents are deliberately not reset.
module dmem_array #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the data-memory request/response port: one transaction at a
// time, WAIT_CYCLES wait states, byte-lane writes and address-error reporting.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int WORDS       = MEM_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic          r_req_ready;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;

    logic          w_accept;
    logic          w_access;
    logic          w_a_we;
    logic [31:0]   w_a_addr;
    logic [3:0]    w_a_be;
    logic [31:0]   w_a_wdata;
    logic          w_err;
    logic          w_mem_we;
    logic [31:0]   w_mem_rdata;

    assign w_accept = (r_state == ST_IDLE) && r_req_ready && req_valid;
    assign w_access = ZERO_WAIT ? w_accept : ((r_state == ST_BUSY) && (r_cnt == '0));

    // With no wait states the access happens on the accept edge, so it must
    // use the live request rather than the not-yet-latched copy.
    assign w_a_we    = ZERO_WAIT ? req_we    : r_we;
    assign w_a_addr  = ZERO_WAIT ? req_addr  : r_addr;
    assign w_a_be    = ZERO_WAIT ? req_be    : r_be;
    assign w_a_wdata = ZERO_WAIT ? req_wdata : r_wdata;

    assign w_err    = addr_is_err(w_a_addr);
    assign w_mem_we = w_access && w_a_we && !w_err;

    dmem_array #(
        .WORDS (WORDS),
        .AW    (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_be    (w_a_be),
        .i_idx   (w_a_addr[IDX_MSB:IDX_LSB]),
        .i_wdata (w_a_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_be        <= req_be;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (ZERO_WAIT) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_err;
                            r_rsp_rdata <= (w_a_we || w_err) ? 32'd0 : w_mem_rdata;
                        end else begin
                            r_cnt   <= CNT_LOAD;
                            r_state <= ST_BUSY;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (w_a_we || w_err) ? 32'd0 : w_mem_rdata;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign dbg_state = r_state;

endmodule
